// File: rtl/multicycle_control_fsm.sv
// Multi-cycle DLX sequencing controller: owns phase timing and per-phase write strobes.
// Optional performance counters are built when MCF_PERF_CNT_EN is defined.
//
// state      | meaning
// FETCH      | latch IR, PC += 4
// DECODE     | classify latched opcode, trap unknown opcodes
// EXECUTE    | jumps/branches retire here, FPU multiply starts here
// FPU_WAIT   | count down the remaining FPU multiply latency
// MEM        | hold data-memory request until mem_ready
// WRITEBACK  | register-file write and retirement
module multicycle_control_fsm #(
    parameter int FPU_LATENCY = 4,
    parameter int LAT_W       = 4,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] instruction,
    input  logic        stall,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic        IR_WR,
    output logic        PC_WR,
    output logic        PC_TGT_WR,
    output logic        FPU_START,
    output logic        MEM_RD_EN,
    output logic        MEM_WR_EN,
    output logic        REG_WR_EN,
    output logic        F_REG_WR_EN,
    output logic        instr_done,
    output logic        illegal_instr,
    output logic [0:2]  state
`ifdef MCF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_FPU_WAIT  = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5
    } state_t;

    localparam logic [LAT_W-1:0] LP_LAT_LOAD  = LAT_W'(FPU_LATENCY - 1);
    localparam bit               LP_SKIP_WAIT = (FPU_LATENCY <= 1);

    if (FPU_LATENCY < 1 || FPU_LATENCY > 15 || FPU_LATENCY > (2 ** LAT_W) || CNT_W < 1)
    begin : g_param_check
        $error("multicycle_control_fsm: illegal FPU_LATENCY/LAT_W/CNT_W");
    end

    state_t           r_state, w_state_nxt;
    logic [LAT_W-1:0] r_cnt, w_cnt_nxt;
    logic [5:0]       r_opcode, r_func;

    logic w_is_alu, w_is_fpu, w_is_jmp, w_is_link, w_is_br, w_is_imm;
    logic w_is_load, w_is_store, w_legal, w_fpu_mul;
    logic w_alu_int_wr, w_wr_fp, w_wr_int;
    logic w_unused;

    // Only opcode and func fields matter for sequencing.
    assign w_unused = ^instruction[6:25];

    assign w_is_alu   = (r_opcode == 6'h00);
    assign w_is_fpu   = (r_opcode == 6'h01);
    assign w_is_jmp   = (r_opcode == 6'h02) || (r_opcode == 6'h12);
    assign w_is_link  = (r_opcode == 6'h03) || (r_opcode == 6'h13);
    assign w_is_br    = (r_opcode == 6'h04) || (r_opcode == 6'h05);
    assign w_is_imm   = ((r_opcode >= 6'h08) && (r_opcode <= 6'h0F)) ||
                        ((r_opcode >= 6'h14) && (r_opcode <= 6'h1D));
    assign w_is_load  = (r_opcode >= 6'h20) && (r_opcode <= 6'h26);
    assign w_is_store = (r_opcode >= 6'h28) && (r_opcode <= 6'h2E);
    assign w_legal    = w_is_alu || w_is_fpu || w_is_jmp || w_is_link || w_is_br ||
                        w_is_imm || w_is_load || w_is_store;

    // FP function codes MULT (0x0E) and MULTU (0x16) use the multi-cycle multiplier.
    assign w_fpu_mul  = w_is_fpu && ((r_func == 6'h0E) || (r_func == 6'h16));

    always_comb begin
        case (r_func)
            6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D,
            6'h34:   w_alu_int_wr = 1'b1;
            default: w_alu_int_wr = 1'b0;
        endcase
    end

    assign w_wr_fp  = w_is_fpu || (r_opcode == 6'h26) || (w_is_alu && (r_func == 6'h35));
    assign w_wr_int = (w_is_alu && w_alu_int_wr) || w_is_imm ||
                      (w_is_load && (r_opcode != 6'h26));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        IR_WR         = 1'b0;
        PC_WR         = 1'b0;
        PC_TGT_WR     = 1'b0;
        FPU_START     = 1'b0;
        MEM_RD_EN     = 1'b0;
        MEM_WR_EN     = 1'b0;
        REG_WR_EN     = 1'b0;
        F_REG_WR_EN   = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        if (!reset && !stall) begin
            case (r_state)
                S_FETCH: begin
                    IR_WR       = 1'b1;
                    PC_WR       = 1'b1;
                    w_state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        illegal_instr = 1'b1;
                        w_state_nxt   = S_FETCH;
                    end else begin
                        w_state_nxt   = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (w_is_jmp || w_is_link) begin
                        PC_TGT_WR   = 1'b1;
                        REG_WR_EN   = w_is_link;
                        instr_done  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else if (w_is_br) begin
                        PC_TGT_WR   = branch_cond;
                        instr_done  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else if (w_fpu_mul) begin
                        FPU_START   = 1'b1;
                        w_cnt_nxt   = LP_LAT_LOAD;
                        w_state_nxt = LP_SKIP_WAIT ? S_WRITEBACK : S_FPU_WAIT;
                    end else if (w_is_load || w_is_store) begin
                        w_state_nxt = S_MEM;
                    end else begin
                        w_state_nxt = S_WRITEBACK;
                    end
                end
                S_FPU_WAIT: begin
                    // Exit on the cycle the decrement lands on zero: LATENCY-1 cycles here.
                    if (r_cnt <= LAT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WRITEBACK;
                    end else begin
                        w_cnt_nxt   = r_cnt - LAT_W'(1);
                    end
                end
                S_MEM: begin
                    MEM_RD_EN = w_is_load;
                    MEM_WR_EN = w_is_store;
                    if (mem_ready && w_is_store) begin
                        instr_done  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else if (mem_ready && w_is_load) begin
                        w_state_nxt = S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    F_REG_WR_EN = w_wr_fp;
                    REG_WR_EN   = w_wr_int && !w_wr_fp;
                    instr_done  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_cnt    <= '0;
            r_opcode <= '0;
            r_func   <= '0;
        end else if (!stall) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (IR_WR) begin
                r_opcode <= instruction[0:5];
                r_func   <= instruction[26:31];
            end
        end
    end

    assign state = r_state;

`ifdef MCF_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_count, r_instr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else if (!stall) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (instr_done) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one DUT at FPU_LATENCY=4, one at FPU_LATENCY=1.
module tb_multicycle_control_fsm;

    localparam logic [9:0] IRW  = 10'h200;
    localparam logic [9:0] PCW  = 10'h100;
    localparam logic [9:0] PCT  = 10'h080;
    localparam logic [9:0] FST  = 10'h040;
    localparam logic [9:0] MRD  = 10'h020;
    localparam logic [9:0] MWR  = 10'h010;
    localparam logic [9:0] REG  = 10'h008;
    localparam logic [9:0] FREG = 10'h004;
    localparam logic [9:0] DONE = 10'h002;
    localparam logic [9:0] ILL  = 10'h001;
    localparam logic [9:0] NONE = 10'h000;

    logic        clk = 1'b0;
    logic        reset, stall, mem_ready, branch_cond;
    logic [0:31] instruction;

    logic       a_irw, a_pcw, a_pct, a_fst, a_mrd, a_mwr, a_reg, a_freg, a_done, a_ill;
    logic       b_irw, b_pcw, b_pct, b_fst, b_mrd, b_mwr, b_reg, b_freg, b_done, b_ill;
    logic [0:2] a_state, b_state;
    logic [9:0] sb0, sb1;
`ifdef MCF_PERF_CNT_EN
    logic [31:0] a_cyc, a_ins, b_cyc, b_ins;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.FPU_LATENCY(4), .LAT_W(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall),
        .mem_ready(mem_ready), .branch_cond(branch_cond),
        .IR_WR(a_irw), .PC_WR(a_pcw), .PC_TGT_WR(a_pct), .FPU_START(a_fst),
        .MEM_RD_EN(a_mrd), .MEM_WR_EN(a_mwr), .REG_WR_EN(a_reg), .F_REG_WR_EN(a_freg),
        .instr_done(a_done), .illegal_instr(a_ill), .state(a_state)
`ifdef MCF_PERF_CNT_EN
        , .cycle_count(a_cyc), .instr_count(a_ins)
`endif
    );

    multicycle_control_fsm #(.FPU_LATENCY(1), .LAT_W(4), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall),
        .mem_ready(mem_ready), .branch_cond(branch_cond),
        .IR_WR(b_irw), .PC_WR(b_pcw), .PC_TGT_WR(b_pct), .FPU_START(b_fst),
        .MEM_RD_EN(b_mrd), .MEM_WR_EN(b_mwr), .REG_WR_EN(b_reg), .F_REG_WR_EN(b_freg),
        .instr_done(b_done), .illegal_instr(b_ill), .state(b_state)
`ifdef MCF_PERF_CNT_EN
        , .cycle_count(b_cyc), .instr_count(b_ins)
`endif
    );

    assign sb0 = {a_irw, a_pcw, a_pct, a_fst, a_mrd, a_mwr, a_reg, a_freg, a_done, a_ill};
    assign sb1 = {b_irw, b_pcw, b_pct, b_fst, b_mrd, b_mwr, b_reg, b_freg, b_done, b_ill};

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'h0, fn};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven just after a falling edge; outputs are sampled 1ns later.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] sb);
        #1;
        chk({tag, ".st"}, 16'(a_state), 16'(st));
        chk({tag, ".sb"}, 16'(sb0), 16'(sb));
        @(negedge clk);
    endtask

    task automatic cyc2(input string tag, input logic [2:0] st, input logic [9:0] sb,
                        input logic [2:0] st1, input logic [9:0] sbb);
        #1;
        chk({tag, ".st"}, 16'(a_state), 16'(st));
        chk({tag, ".sb"}, 16'(sb0), 16'(sb));
        chk({tag, ".st1"}, 16'(b_state), 16'(st1));
        chk({tag, ".sb1"}, 16'(sb1), 16'(sbb));
        @(negedge clk);
    endtask

    task automatic start(input logic [31:0] instr);
        reset       = 1'b1;
        stall       = 1'b0;
        mem_ready   = 1'b0;
        branch_cond = 1'b0;
        instruction = instr;
        #1;
        chk("rst.sb", 16'(sb0), 16'(NONE));
        chk("rst.sb1", 16'(sb1), 16'(NONE));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; mem_ready = 1'b0; branch_cond = 1'b0;
        instruction = '1;
        @(negedge clk);

        // ADD
        start(mk(6'h00, 6'h20));
        cyc("add1", 3'd0, IRW | PCW);
        instruction = '1;
        cyc("add2", 3'd1, NONE);
        cyc("add3", 3'd2, NONE);
        cyc("add4", 3'd5, REG | DONE);
        cyc("add5", 3'd0, IRW | PCW);

        // LW, stray mem_ready during EXECUTE, ready on 4th MEM cycle
        start(mk(6'h23, 6'h00));
        cyc("lw1", 3'd0, IRW | PCW);
        instruction = '1;
        cyc("lw2", 3'd1, NONE);
        mem_ready = 1'b1;
        cyc("lw3", 3'd2, NONE);
        mem_ready = 1'b0;
        cyc("lw4", 3'd4, MRD);
        cyc("lw5", 3'd4, MRD);
        cyc("lw6", 3'd4, MRD);
        mem_ready = 1'b1;
        cyc("lw7", 3'd4, MRD);
        mem_ready = 1'b0;
        cyc("lw8", 3'd5, REG | DONE);
        cyc("lw9", 3'd0, IRW | PCW);

        // FPU MULT, latency 4 vs latency 1
        start(mk(6'h01, 6'h0E));
        cyc2("mul1", 3'd0, IRW | PCW, 3'd0, IRW | PCW);
        instruction = '1;
        cyc2("mul2", 3'd1, NONE, 3'd1, NONE);
        cyc2("mul3", 3'd2, FST, 3'd2, FST);
        cyc2("mul4", 3'd3, NONE, 3'd5, FREG | DONE);
        cyc("mul5", 3'd3, NONE);
        cyc("mul6", 3'd3, NONE);
        cyc("mul7", 3'd5, FREG | DONE);
        cyc("mul8", 3'd0, IRW | PCW);

        // MULTU with 2-cycle stall inside FPU_WAIT
        start(mk(6'h01, 6'h16));
        cyc("stl1", 3'd0, IRW | PCW);
        instruction = '1;
        cyc("stl2", 3'd1, NONE);
        cyc("stl3", 3'd2, FST);
        cyc("stl4", 3'd3, NONE);
        stall = 1'b1;
        cyc("stl5", 3'd3, NONE);
        cyc("stl6", 3'd3, NONE);
        stall = 1'b0;
        cyc("stl7", 3'd3, NONE);
        cyc("stl8", 3'd3, NONE);
        cyc("stl9", 3'd5, FREG | DONE);

        // BEQZ taken / not taken
        start(mk(6'h04, 6'h00));
        cyc("bt1", 3'd0, IRW | PCW);
        instruction = '1;
        cyc("bt2", 3'd1, NONE);
        branch_cond = 1'b1;
        cyc("bt3", 3'd2, PCT | DONE);
        branch_cond = 1'b0;
        cyc("bt4", 3'd0, IRW | PCW);

        start(mk(6'h04, 6'h00));
        cyc("bn1", 3'd0, IRW | PCW);
        instruction = '1;
        cyc("bn2", 3'd1, NONE);
        cyc("bn3", 3'd2, DONE);
        cyc("bn4", 3'd0, IRW | PCW);

        // JAL link write
        start(mk(6'h03, 6'h00));
        cyc("jal1", 3'd0, IRW | PCW);
        cyc("jal2", 3'd1, NONE);
        cyc("jal3", 3'd2, PCT | REG | DONE);

        // SW abandoned by reset in second MEM cycle
        start(mk(6'h2B, 6'h00));
        cyc("swr1", 3'd0, IRW | PCW);
        instruction = '1;
        cyc("swr2", 3'd1, NONE);
        cyc("swr3", 3'd2, NONE);
        cyc("swr4", 3'd4, MWR);
        reset = 1'b1;
        cyc("swr5", 3'd4, NONE);
        reset = 1'b0;
        cyc("swr6", 3'd0, IRW | PCW);

        // SW zero-wait completion
        start(mk(6'h2B, 6'h00));
        cyc("sw01", 3'd0, IRW | PCW);
        cyc("sw02", 3'd1, NONE);
        cyc("sw03", 3'd2, NONE);
        mem_ready = 1'b1;
        cyc("sw04", 3'd4, MWR | DONE);
        mem_ready = 1'b0;
        cyc("sw05", 3'd0, IRW | PCW);

        // LB with stall in MEM: request drops, mem_ready ignored
        start(mk(6'h20, 6'h00));
        cyc("lbs1", 3'd0, IRW | PCW);
        cyc("lbs2", 3'd1, NONE);
        cyc("lbs3", 3'd2, NONE);
        stall = 1'b1; mem_ready = 1'b1;
        cyc("lbs4", 3'd4, NONE);
        stall = 1'b0; mem_ready = 1'b0;
        cyc("lbs5", 3'd4, MRD);
        mem_ready = 1'b1;
        cyc("lbs6", 3'd4, MRD);
        mem_ready = 1'b0;
        cyc("lbs7", 3'd5, REG | DONE);

        // LF writes FP register file
        start(mk(6'h26, 6'h00));
        cyc("lf1", 3'd0, IRW | PCW);
        cyc("lf2", 3'd1, NONE);
        cyc("lf3", 3'd2, NONE);
        mem_ready = 1'b1;
        cyc("lf4", 3'd4, MRD);
        mem_ready = 1'b0;
        cyc("lf5", 3'd5, FREG | DONE);

        // Illegal opcode
        start(mk(6'h3F, 6'h00));
        cyc("ill1", 3'd0, IRW | PCW);
        cyc("ill2", 3'd1, ILL);
        cyc("ill3", 3'd0, IRW | PCW);

        // NOP, MOVI2FP, unknown ALU func, ADDI
        start(mk(6'h00, 6'h00));
        cyc("nop1", 3'd0, IRW | PCW);
        cyc("nop2", 3'd1, NONE);
        cyc("nop3", 3'd2, NONE);
        cyc("nop4", 3'd5, DONE);

        start(mk(6'h00, 6'h35));
        cyc("mvf1", 3'd0, IRW | PCW);
        cyc("mvf2", 3'd1, NONE);
        cyc("mvf3", 3'd2, NONE);
        cyc("mvf4", 3'd5, FREG | DONE);

        start(mk(6'h00, 6'h3F));
        cyc("unk1", 3'd0, IRW | PCW);
        cyc("unk2", 3'd1, NONE);
        cyc("unk3", 3'd2, NONE);
        cyc("unk4", 3'd5, DONE);

        start(mk(6'h08, 6'h00));
        cyc("adi1", 3'd0, IRW | PCW);
        cyc("adi2", 3'd1, NONE);
        cyc("adi3", 3'd2, NONE);
        cyc("adi4", 3'd5, REG | DONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
